// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Holds the fetch FSM state encoding, datapath widths and the halfword-align helper.
package pc_fetch_ctrl_pkg;

   localparam int ADDR_W  = 16;
   localparam int INSTR_W = 16;
   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_MISS  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

   // Instructions are halfword aligned, so the redirect LSB is forced to zero.
   function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
      return addr & {{(ADDR_W-1){1'b1}}, 1'b0};
   endfunction

endpackage

// File: rtl/pc_fetch_ctrl_ifid_reg.sv
// IF/ID pipeline register: clear drops the valid bit, load captures a new
// instruction and its link PC, and with neither asserted the contents hold.
module pc_fetch_ctrl_ifid_reg
   import pc_fetch_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               clear,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [ADDR_W-1:0]  pc_in,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= instr_in;
         pc    <= pc_in;
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch controller: drives the icache request, tracks misses and
// pending redirects, and loads the IF/ID register.
// Per-cycle priority outside DRAIN is stall, then br_taken, then ic_ready.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int                PC_INC   = 2
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               br_taken,
   input  logic [ADDR_W-1:0]  br_target,
   output logic               ic_req,
   output logic [ADDR_W-1:0]  ic_addr,
   input  logic               ic_ready,
   input  logic [INSTR_W-1:0] ic_instr,
   output logic               ifid_valid,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0]  ifid_pc,
   output logic               flush,
   output fetch_state_t       state
);

   fetch_state_t      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] redir_pc_q;
   logic [ADDR_W-1:0] pc_next_seq;
   logic [ADDR_W-1:0] br_aligned;
   logic              ifid_load;
   logic              ifid_clear;

   assign pc_next_seq = pc_q + ADDR_W'(PC_INC);
   assign br_aligned  = align_addr(br_target);

   // In DRAIN the pc is never advanced, so it still equals the missed address.
   assign ic_req  = rst_n;
   assign ic_addr = pc_q;
   assign state   = state_q;

   always_comb begin
      ifid_load  = 1'b0;
      ifid_clear = 1'b0;
      flush      = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_RUN, ST_MISS: begin
               if (!stall) begin
                  if (br_taken) begin
                     ifid_clear = 1'b1;
                     flush      = 1'b1;
                  end else if (ic_ready) begin
                     ifid_load  = 1'b1;
                  end else begin
                     ifid_clear = 1'b1;
                  end
               end
            end
            default: ifid_clear = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         redir_pc_q <= '0;
      end else begin
         case (state_q)
            ST_RUN, ST_MISS: begin
               if (stall) begin
                  // A stalled miss that completes simply re-fetches once ID frees up.
                  if (state_q == ST_MISS && ic_ready) state_q <= ST_RUN;
               end else if (br_taken) begin
                  if (ic_ready) begin
                     pc_q    <= br_aligned;
                     state_q <= ST_RUN;
                  end else begin
                     redir_pc_q <= br_aligned;
                     state_q    <= ST_DRAIN;
                  end
               end else if (ic_ready) begin
                  pc_q    <= pc_next_seq;
                  state_q <= ST_RUN;
               end else begin
                  state_q <= ST_MISS;
               end
            end
            ST_DRAIN: begin
               if (ic_ready) begin
                  pc_q    <= redir_pc_q;
                  state_q <= ST_RUN;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   pc_fetch_ctrl_ifid_reg u_ifid_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ifid_load),
      .clear    (ifid_clear),
      .instr_in (ic_instr),
      .pc_in    (pc_next_seq),
      .valid    (ifid_valid),
      .instr    (ifid_instr),
      .pc       (ifid_pc)
   );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: hand-computed expectations for sequential
// fetch, stalls, misses, redirects, DRAIN, PC wrap and reset during DRAIN.
module tb_pc_fetch_ctrl;
   import pc_fetch_ctrl_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         stall;
   logic         br_taken;
   logic [15:0]  br_target;
   logic         ic_req;
   logic [15:0]  ic_addr;
   logic         ic_ready;
   logic [15:0]  ic_instr;
   logic         ifid_valid;
   logic [15:0]  ifid_instr;
   logic [15:0]  ifid_pc;
   logic         flush;
   fetch_state_t state;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   pc_fetch_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .ic_req     (ic_req),
      .ic_addr    (ic_addr),
      .ic_ready   (ic_ready),
      .ic_instr   (ic_instr),
      .ifid_valid (ifid_valid),
      .ifid_instr (ifid_instr),
      .ifid_pc    (ifid_pc),
      .flush      (flush),
      .state      (state)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply one cycle's inputs and let combinational outputs settle.
   task automatic drive(input logic s, input logic br, input logic [15:0] tgt,
                        input logic rdy, input logic [15:0] instr);
      stall     = s;
      br_taken  = br;
      br_target = tgt;
      ic_ready  = rdy;
      ic_instr  = instr;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 16'h0000, 0, 16'h0000);
      #2;
      check_eq("rst_ic_req", 32'(ic_req), 0);
      check_eq("rst_ifid_valid", 32'(ifid_valid), 0);
      check_eq("rst_ifid_instr", 32'(ifid_instr), 0);
      check_eq("rst_ifid_pc", 32'(ifid_pc), 0);
      check_eq("rst_flush", 32'(flush), 0);
      check_eq("rst_ic_addr", 32'(ic_addr), 0);
      check_eq("rst_state", 32'(state), 32'(ST_RUN));
      tick();
      rst_n = 1'b1;

      // Sequential hits from reset
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 16'h0000, 1, 16'h1000 + 16'(2*i));
         check_eq("seq_ic_addr", 32'(ic_addr), 32'(2*i));
         check_eq("seq_ic_req", 32'(ic_req), 1);
         tick();
         check_eq("seq_valid", 32'(ifid_valid), 1);
         check_eq("seq_ifid_pc", 32'(ifid_pc), 32'(2*i + 2));
         check_eq("seq_ifid_instr", 32'(ifid_instr), 32'(16'h1000 + 16'(2*i)));
      end

      // Stall two cycles at 0008, branch during stall ignored
      for (int i = 0; i < 2; i++) begin
         drive(1, 1, 16'h0200, 1, 16'h1008);
         check_eq("stall_flush", 32'(flush), 0);
         check_eq("stall_ic_addr", 32'(ic_addr), 32'h0008);
         tick();
         check_eq("stall_ifid_pc", 32'(ifid_pc), 32'h0008);
         check_eq("stall_ifid_instr", 32'(ifid_instr), 32'h1006);
         check_eq("stall_valid", 32'(ifid_valid), 1);
      end
      drive(0, 0, 16'h0000, 1, 16'h1008);
      check_eq("resume_ic_addr", 32'(ic_addr), 32'h0008);
      tick();
      check_eq("resume_ifid_pc", 32'(ifid_pc), 32'h000A);
      check_eq("resume_ifid_instr", 32'(ifid_instr), 32'h1008);

      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 16'h0000, 1, 16'h100A + 16'(2*i));
         tick();
      end

      // Taken branch on a hit at 0010, target 0041
      drive(0, 1, 16'h0041, 1, 16'h1010);
      check_eq("br_ic_addr", 32'(ic_addr), 32'h0010);
      check_eq("br_flush", 32'(flush), 1);
      tick();
      check_eq("br_bubble", 32'(ifid_valid), 0);
      drive(0, 0, 16'h0000, 1, 16'h1040);
      check_eq("br_target_addr", 32'(ic_addr), 32'h0040);
      check_eq("br_flush_clear", 32'(flush), 0);
      tick();
      check_eq("br_tgt_valid", 32'(ifid_valid), 1);
      check_eq("br_tgt_instr", 32'(ifid_instr), 32'h1040);
      check_eq("br_tgt_pc", 32'(ifid_pc), 32'h0042);

      // Miss at 0020 for three cycles
      drive(0, 1, 16'h0020, 1, 16'h0000);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 16'h0000, 0, 16'hDEAD);
         check_eq("miss_ic_addr", 32'(ic_addr), 32'h0020);
         tick();
         check_eq("miss_valid", 32'(ifid_valid), 0);
         check_eq("miss_state", 32'(state), 32'(ST_MISS));
      end
      drive(0, 0, 16'h0000, 1, 16'h1020);
      check_eq("miss_done_addr", 32'(ic_addr), 32'h0020);
      tick();
      check_eq("miss_done_valid", 32'(ifid_valid), 1);
      check_eq("miss_done_pc", 32'(ifid_pc), 32'h0022);
      check_eq("miss_done_instr", 32'(ifid_instr), 32'h1020);
      check_eq("miss_done_state", 32'(state), 32'(ST_RUN));

      // Miss at 0030 then redirect to 0100 in first miss cycle
      drive(0, 1, 16'h0030, 1, 16'h0000);
      tick();
      drive(0, 0, 16'h0000, 0, 16'h0000);
      tick();
      check_eq("drn_miss_state", 32'(state), 32'(ST_MISS));
      drive(0, 1, 16'h0100, 0, 16'h0000);
      check_eq("drn_flush", 32'(flush), 1);
      check_eq("drn_ic_addr", 32'(ic_addr), 32'h0030);
      tick();
      check_eq("drn_state", 32'(state), 32'(ST_DRAIN));
      check_eq("drn_valid", 32'(ifid_valid), 0);
      drive(0, 1, 16'h0300, 0, 16'hBEEF);
      check_eq("drn_ign_flush", 32'(flush), 0);
      check_eq("drn_hold_addr", 32'(ic_addr), 32'h0030);
      tick();
      check_eq("drn_hold_state", 32'(state), 32'(ST_DRAIN));
      drive(1, 1, 16'h0300, 1, 16'hBEEF);
      check_eq("drn_end_flush", 32'(flush), 0);
      tick();
      check_eq("drn_end_state", 32'(state), 32'(ST_RUN));
      check_eq("drn_discard", 32'(ifid_valid), 0);
      drive(0, 0, 16'h0000, 1, 16'h1100);
      check_eq("drn_redir_addr", 32'(ic_addr), 32'h0100);
      tick();
      check_eq("drn_redir_instr", 32'(ifid_instr), 32'h1100);
      check_eq("drn_redir_pc", 32'(ifid_pc), 32'h0102);

      // PC wrap at FFFE
      drive(0, 1, 16'hFFFF, 1, 16'h0000);
      tick();
      drive(0, 0, 16'h0000, 1, 16'h1FFE);
      check_eq("wrap_ic_addr", 32'(ic_addr), 32'hFFFE);
      tick();
      check_eq("wrap_ifid_pc", 32'(ifid_pc), 32'h0000);
      check_eq("wrap_ifid_instr", 32'(ifid_instr), 32'h1FFE);
      drive(0, 0, 16'h0000, 0, 16'h0000);
      check_eq("wrap_next_addr", 32'(ic_addr), 32'h0000);

      // Reset asserted during DRAIN
      drive(0, 1, 16'h0500, 0, 16'h0000);
      tick();
      check_eq("rstdrn_state", 32'(state), 32'(ST_DRAIN));
      rst_n = 1'b0;
      #1;
      check_eq("rstdrn_ic_req", 32'(ic_req), 0);
      check_eq("rstdrn_state_rst", 32'(state), 32'(ST_RUN));
      check_eq("rstdrn_ic_addr", 32'(ic_addr), 32'h0000);
      check_eq("rstdrn_ifid_pc", 32'(ifid_pc), 32'h0000);
      rst_n = 1'b1;
      drive(0, 0, 16'h0000, 1, 16'h1234);
      check_eq("rstdrn_first_addr", 32'(ic_addr), 32'h0000);
      tick();
      check_eq("rstdrn_first_pc", 32'(ifid_pc), 32'h0002);

      // Miss with stall: completion returns to RUN without loading
      drive(0, 0, 16'h0000, 0, 16'h0000);
      tick();
      check_eq("mstall_state", 32'(state), 32'(ST_MISS));
      drive(1, 0, 16'h0000, 1, 16'h5555);
      tick();
      check_eq("mstall_ret_state", 32'(state), 32'(ST_RUN));
      check_eq("mstall_no_load", 32'(ifid_valid), 0);
      drive(0, 0, 16'h0000, 1, 16'h2002);
      check_eq("mstall_refetch", 32'(ic_addr), 32'h0002);
      tick();
      check_eq("mstall_instr", 32'(ifid_instr), 32'h2002);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
